// File: rtl/execute_calc_mc.sv
// rtl/execute_calc_mc.sv - multi-cycle execute stage with radix-2 divider and registered result bundle
module execute_calc_mc #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [3:0]        in_br_op,
    input  logic [1:0]        in_mem_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_use_rs2,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu_result,
    output logic              out_cmp_eq,
    output logic              branch_taken_out,
    output logic [XLEN-1:0]   branch_target_out,
    output logic              mem_write_out,
    output logic              mem_read_out,
    output logic [XLEN-1:0]   mem_addr_out,
    output logic [XLEN-1:0]   mem_data_out,
    output logic [MASK_W-1:0] mem_mask_out,
    output logic              busy_out
);
    localparam logic [3:0] ALU_NONE = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,  ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4,  ALU_XOR  = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8,  ALU_SLT  = 4'd9,  ALU_SLTU = 4'd10, ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_MULH = 4'd12, ALU_DIV  = 4'd13, ALU_REM  = 4'd14, ALU_PASS = 4'd15;

    localparam logic [3:0] BR_NONE = 4'd0, BR_BEQ  = 4'd1, BR_BNE  = 4'd2,  BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4, BR_BLTU = 4'd5, BR_BGEU = 4'd6,  BR_BEQZ = 4'd7;
    localparam logic [3:0] BR_BNEZ = 4'd8, BR_JAL  = 4'd9, BR_JALR = 4'd10, BR_JR   = 4'd11;

    localparam logic [1:0] MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2;

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_a, r_b, r_rs2, r_imm, r_pc, r_quo, r_rem;
    logic [3:0]        r_alu_op, r_br_op;
    logic [1:0]        r_mem_op;
    logic [2:0]        r_funct3;

    logic              r_valid, r_eq, r_taken, r_mem_wr, r_mem_rd;
    logic [XLEN-1:0]   r_result, r_target, r_addr, r_data;
    logic [MASK_W-1:0] r_mask;

    logic              w_in_div, w_out_free, w_accept, w_is_div, w_div_done, w_load;
    logic [XLEN-1:0]   w_b_in, w_alu, w_a, w_b, w_imm, w_pc, w_rs2, w_result, w_target, w_sum_jr;
    logic [2*XLEN-1:0] w_prod;
    logic [SH_W-1:0]   w_shamt;
    logic [3:0]        w_br_op;
    logic [1:0]        w_mem_op;
    logic [2:0]        w_funct3;
    logic              w_eq, w_taken, w_mem_wr, w_mem_rd, w_q_bit;
    logic [MASK_W-1:0] w_mask;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_rem_sub;

    assign w_in_div   = (r_state == S_DIV);
    assign w_out_free = !r_valid || out_ready;
    assign in_ready   = (r_state == S_IDLE) && w_out_free && reset;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_is_div   = (in_alu_op == ALU_DIV) || (in_alu_op == ALU_REM);
    assign w_div_done = w_in_div && (r_cnt == CNT_LAST);
    assign w_load     = (w_accept && !w_is_div) || (w_div_done && w_out_free);

    // Address generation for loads/stores always takes the immediate.
    always_comb begin
        w_b_in = in_imm;
        if (in_alu_op == ALU_ADD && in_mem_op != MEM_NONE)
            w_b_in = in_imm;
        else if (in_use_rs2 || in_br_op == BR_BEQZ || in_br_op == BR_BNEZ)
            w_b_in = in_rs2_val;
    end

    assign w_shamt = w_b_in[SH_W-1:0];
    assign w_prod  = {{XLEN{1'b0}}, in_rs1_val} * {{XLEN{1'b0}}, w_b_in};

    always_comb begin
        w_alu = '0;
        case (in_alu_op)
            ALU_ADD:  w_alu = in_rs1_val + w_b_in;
            ALU_SUB:  w_alu = in_rs1_val - w_b_in;
            ALU_AND:  w_alu = in_rs1_val & w_b_in;
            ALU_OR:   w_alu = in_rs1_val | w_b_in;
            ALU_XOR:  w_alu = in_rs1_val ^ w_b_in;
            ALU_SLL:  w_alu = in_rs1_val << w_shamt;
            ALU_SRL:  w_alu = in_rs1_val >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(in_rs1_val) >>> w_shamt);
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(in_rs1_val) < $signed(w_b_in))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (in_rs1_val < w_b_in)};
            ALU_MUL:  w_alu = w_prod[XLEN-1:0];
            ALU_MULH: w_alu = w_prod[2*XLEN-1:XLEN];
            ALU_PASS: w_alu = w_b_in;
            ALU_NONE: w_alu = '0;
            default:  w_alu = '0;
        endcase
    end

    // While dividing, the bundle is built from the operands captured at accept.
    assign w_a      = w_in_div ? r_a      : in_rs1_val;
    assign w_b      = w_in_div ? r_b      : w_b_in;
    assign w_imm    = w_in_div ? r_imm    : in_imm;
    assign w_pc     = w_in_div ? r_pc     : in_pc;
    assign w_rs2    = w_in_div ? r_rs2    : in_rs2_val;
    assign w_br_op  = w_in_div ? r_br_op  : in_br_op;
    assign w_mem_op = w_in_div ? r_mem_op : in_mem_op;
    assign w_funct3 = w_in_div ? r_funct3 : in_funct3;
    assign w_result = w_in_div ? ((r_alu_op == ALU_REM) ? r_rem : r_quo) : w_alu;
    assign w_eq     = (w_a == w_b);
    assign w_sum_jr = w_a + w_imm;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc + w_imm;
        case (w_br_op)
            BR_BEQ, BR_BEQZ:  w_taken = w_eq;
            BR_BNE, BR_BNEZ:  w_taken = !w_eq;
            BR_BLT, BR_BLTU:  w_taken = w_result[0];
            BR_BGE, BR_BGEU:  w_taken = !w_result[0];
            BR_JAL:           w_taken = 1'b1;
            BR_JALR, BR_JR: begin
                w_taken  = 1'b1;
                w_target = w_sum_jr & {{(XLEN-1){1'b1}}, 1'b0};
            end
            BR_NONE:          w_target = '0;
            default:          w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_mem_wr = 1'b0;
        w_mem_rd = 1'b0;
        w_mask   = '0;
        if (w_mem_op == MEM_STORE) begin
            case (w_funct3)
                3'd0: begin w_mem_wr = 1'b1; w_mask = MASK_W'(8'h01); end
                3'd1: begin w_mem_wr = 1'b1; w_mask = MASK_W'(8'h03); end
                3'd2: begin w_mem_wr = 1'b1; w_mask = MASK_W'(8'h0F); end
                3'd3: if (XLEN == 64) begin w_mem_wr = 1'b1; w_mask = MASK_W'(8'hFF); end
                default: w_mem_wr = 1'b0;
            endcase
        end else if (w_mem_op == MEM_LOAD) begin
            case (w_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_mem_rd = 1'b1;
                3'd3, 3'd6:                   w_mem_rd = (XLEN == 64);
                default:                      w_mem_rd = 1'b0;
            endcase
        end
    end

    // Restoring divide: one quotient bit per cycle; a zero divisor naturally yields all-ones / a.
    assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    assign w_q_bit   = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_alu_op <= ALU_NONE;
            r_br_op  <= BR_NONE;
            r_mem_op <= MEM_NONE;
            r_funct3 <= '0;
            r_valid  <= 1'b0;
            r_eq     <= 1'b0;
            r_taken  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_result <= '0;
            r_target <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_mask   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_result <= w_result;
                r_eq     <= w_eq;
                r_taken  <= w_taken;
                r_target <= w_target;
                r_mem_wr <= w_mem_wr;
                r_mem_rd <= w_mem_rd;
                r_addr   <= w_result;
                r_data   <= w_rs2;
                r_mask   <= w_mask;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_div) begin
                        r_state  <= S_DIV;
                        r_cnt    <= '0;
                        r_a      <= in_rs1_val;
                        r_b      <= w_b_in;
                        r_rs2    <= in_rs2_val;
                        r_imm    <= in_imm;
                        r_pc     <= in_pc;
                        r_quo    <= in_rs1_val;
                        r_rem    <= '0;
                        r_alu_op <= in_alu_op;
                        r_br_op  <= in_br_op;
                        r_mem_op <= in_mem_op;
                        r_funct3 <= in_funct3;
                    end
                end
                S_DIV: begin
                    if (!w_div_done) begin
                        r_rem <= w_q_bit ? w_rem_sub : w_rem_sh[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_out_free) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid         = r_valid;
    assign out_alu_result    = r_result;
    assign out_cmp_eq        = r_eq;
    assign branch_taken_out  = r_taken;
    assign branch_target_out = r_target;
    assign mem_write_out     = r_valid && r_mem_wr;
    assign mem_read_out      = r_valid && r_mem_rd;
    assign mem_addr_out      = r_addr;
    assign mem_data_out      = r_data;
    assign mem_mask_out      = r_mask;
    assign busy_out          = w_in_div;
endmodule

// File: tb/tb_execute_calc_mc.sv
// tb/tb_execute_calc_mc.sv - directed and randomized check of execute_calc_mc against a behavioural model
module tb_execute_calc_mc;
    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    localparam logic [3:0] A_NONE = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4;
    localparam logic [3:0] A_XOR = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8, A_SLT = 4'd9;
    localparam logic [3:0] A_SLTU = 4'd10, A_MUL = 4'd11, A_MULH = 4'd12, A_DIV = 4'd13;
    localparam logic [3:0] A_REM = 4'd14, A_PASS = 4'd15;
    localparam logic [3:0] B_NONE = 4'd0, B_BEQ = 4'd1, B_BNE = 4'd2, B_BLT = 4'd3, B_BGE = 4'd4;
    localparam logic [3:0] B_BLTU = 4'd5, B_BGEU = 4'd6, B_BEQZ = 4'd7, B_BNEZ = 4'd8;
    localparam logic [3:0] B_JAL = 4'd9, B_JALR = 4'd10, B_JR = 4'd11;
    localparam logic [1:0] M_NONE = 2'd0, M_LOAD = 2'd1, M_STORE = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush, in_valid, in_ready, out_ready, out_valid, in_use_rs2;
    logic [3:0]        in_alu_op, in_br_op;
    logic [1:0]        in_mem_op;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_rs1_val, in_rs2_val, in_imm, in_pc;
    logic [XLEN-1:0]   out_alu_result, branch_target_out, mem_addr_out, mem_data_out;
    logic              out_cmp_eq, branch_taken_out, mem_write_out, mem_read_out, busy_out;
    logic [MASK_W-1:0] mem_mask_out;

    execute_calc_mc #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_br_op(in_br_op), .in_mem_op(in_mem_op), .in_funct3(in_funct3),
        .in_use_rs2(in_use_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
        .out_cmp_eq(out_cmp_eq), .branch_taken_out(branch_taken_out),
        .branch_target_out(branch_target_out), .mem_write_out(mem_write_out),
        .mem_read_out(mem_read_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_mask_out(mem_mask_out), .busy_out(busy_out)
    );

    logic        x_in_valid, x_in_ready, x_use_rs2, x_out_valid, x_eq, x_bt, x_mw, x_mr, x_busy;
    logic [3:0]  x_alu_op, x_br_op;
    logic [1:0]  x_mem_op;
    logic [2:0]  x_funct3;
    logic [63:0] x_rs1, x_rs2, x_imm, x_pc, x_res, x_tgt, x_addr, x_data;
    logic [7:0]  x_mask;

    execute_calc_mc #(.XLEN(64), .MASK_W(8)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_alu_op(x_alu_op), .in_br_op(x_br_op), .in_mem_op(x_mem_op), .in_funct3(x_funct3),
        .in_use_rs2(x_use_rs2), .in_rs1_val(x_rs1), .in_rs2_val(x_rs2), .in_imm(x_imm),
        .in_pc(x_pc), .out_valid(x_out_valid), .out_ready(1'b1), .out_alu_result(x_res),
        .out_cmp_eq(x_eq), .branch_taken_out(x_bt), .branch_target_out(x_tgt),
        .mem_write_out(x_mw), .mem_read_out(x_mr), .mem_addr_out(x_addr), .mem_data_out(x_data),
        .mem_mask_out(x_mask), .busy_out(x_busy)
    );

    typedef struct packed {
        logic [XLEN-1:0]   res;
        logic              eq;
        logic              bt;
        logic [XLEN-1:0]   tgt;
        logic              mw;
        logic              mr;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [MASK_W-1:0] mask;
    } bund_t;

    int    total = 0, bad = 0;
    int    m_div_left = 0, m_reads = 0, d_reads = 0;
    logic  m_valid = 1'b0, m_zero = 1'b1, started = 1'b0;
    bund_t m_b = '0, m_div_b = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bund_t calc(input logic [3:0] aop, input logic [3:0] bop, input logic [1:0] mop,
                                   input logic [2:0] f3, input logic use2, input logic [XLEN-1:0] ra,
                                   input logic [XLEN-1:0] rb2, input logic [XLEN-1:0] im,
                                   input logic [XLEN-1:0] p);
        bund_t o;
        logic [XLEN-1:0] b;
        logic [2*XLEN-1:0] wide;
        int sh;
        o = '0;
        if (aop == A_ADD && mop != M_NONE) b = im;
        else if (use2 || bop == B_BEQZ || bop == B_BNEZ) b = rb2;
        else b = im;
        sh = int'(b % XLEN);
        wide = {{XLEN{1'b0}}, ra} * {{XLEN{1'b0}}, b};
        case (aop)
            A_ADD:  o.res = ra + b;
            A_SUB:  o.res = ra - b;
            A_AND:  o.res = ra & b;
            A_OR:   o.res = ra | b;
            A_XOR:  o.res = ra ^ b;
            A_SLL:  o.res = ra << sh;
            A_SRL:  o.res = ra >> sh;
            A_SRA:  o.res = $unsigned($signed(ra) >>> sh);
            A_SLT:  o.res = ($signed(ra) < $signed(b)) ? XLEN'(1) : '0;
            A_SLTU: o.res = (ra < b) ? XLEN'(1) : '0;
            A_MUL:  o.res = wide[XLEN-1:0];
            A_MULH: o.res = wide[2*XLEN-1:XLEN];
            A_DIV:  o.res = (b == 0) ? '1 : ra / b;
            A_REM:  o.res = (b == 0) ? ra : ra % b;
            A_PASS: o.res = b;
            default: o.res = '0;
        endcase
        o.eq = (ra == b);
        case (bop)
            B_BEQ, B_BEQZ:  o.bt = o.eq;
            B_BNE, B_BNEZ:  o.bt = !o.eq;
            B_BLT, B_BLTU:  o.bt = o.res[0];
            B_BGE, B_BGEU:  o.bt = !o.res[0];
            B_JAL, B_JALR, B_JR: o.bt = 1'b1;
            default:        o.bt = 1'b0;
        endcase
        if (bop == B_NONE) o.tgt = '0;
        else if (bop == B_JALR || bop == B_JR) o.tgt = (ra + im) & {{(XLEN-1){1'b1}}, 1'b0};
        else o.tgt = p + im;
        o.addr = o.res;
        o.data = rb2;
        if (mop == M_STORE && int'(f3) <= ((XLEN == 64) ? 3 : 2)) begin
            o.mw   = 1'b1;
            o.mask = MASK_W'((1 << (1 << f3)) - 1);
        end
        o.mr = (mop == M_LOAD) && ((f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                                   (XLEN == 64 && (f3 inside {3'd3, 3'd6})));
        return o;
    endfunction

    // Advances the model by one clock edge using the inputs that were present at that edge.
    task automatic model_step();
        logic rdy, isdiv;
        bund_t nb;
        if (m_valid && out_ready && m_b.mr) m_reads++;
        if (!reset) begin
            m_valid = 1'b0; m_b = '0; m_div_left = 0; m_zero = 1'b1;
            return;
        end
        if (flush) begin
            m_valid = 1'b0; m_div_left = 0;
            return;
        end
        rdy = (m_div_left == 0) && (!m_valid || out_ready);
        if (m_div_left > 0) begin
            m_div_left--;
            if (m_div_left == 0) begin
                m_valid = 1'b1; m_b = m_div_b; m_zero = 1'b0;
            end
        end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (in_valid && rdy) begin
                nb = calc(in_alu_op, in_br_op, in_mem_op, in_funct3, in_use_rs2,
                          in_rs1_val, in_rs2_val, in_imm, in_pc);
                isdiv = (in_alu_op == A_DIV) || (in_alu_op == A_REM);
                if (isdiv) begin
                    m_div_b = nb; m_div_left = XLEN + 1;
                end else begin
                    m_valid = 1'b1; m_b = nb; m_zero = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin : compare
        logic exp_ready;
        if (started) begin
            exp_ready = reset && (m_div_left == 0) && (!m_valid || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("busy", 64'(busy_out), 64'(m_div_left > 0));
            chk("mem_write", 64'(mem_write_out), 64'(m_valid && m_b.mw));
            chk("mem_read", 64'(mem_read_out), 64'(m_valid && m_b.mr));
            if (m_valid || m_zero) begin
                chk("result", 64'(out_alu_result), 64'(m_b.res));
                chk("cmp_eq", 64'(out_cmp_eq), 64'(m_b.eq));
                chk("taken", 64'(branch_taken_out), 64'(m_b.bt));
                chk("target", 64'(branch_target_out), 64'(m_b.tgt));
                chk("addr", 64'(mem_addr_out), 64'(m_b.addr));
                chk("data", 64'(mem_data_out), 64'(m_b.data));
                chk("mask", 64'(mem_mask_out), 64'(m_b.mask));
            end
            if (out_valid && out_ready && mem_read_out) d_reads++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_op(input logic [3:0] aop, input logic [3:0] bop, input logic [1:0] mop,
                          input logic [2:0] f3, input logic use2, input logic [XLEN-1:0] ra,
                          input logic [XLEN-1:0] rb, input logic [XLEN-1:0] im, input logic [XLEN-1:0] p);
        in_alu_op = aop; in_br_op = bop; in_mem_op = mop; in_funct3 = f3; in_use_rs2 = use2;
        in_rs1_val = ra; in_rs2_val = rb; in_imm = im; in_pc = p; in_valid = 1'b1;
    endtask

    task automatic run_div(input string nm, input logic [3:0] aop, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int n;
        set_op(aop, B_NONE, M_NONE, 3'd0, 1'b1, a, b, '0, '0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(XLEN + 1));
        chk({nm, "_result"}, 64'(out_alu_result), 64'(exp));
        tick();
    endtask

    function automatic logic [XLEN-1:0] rv();
        case ($urandom_range(0, 3))
            0: return XLEN'($urandom_range(0, 15));
            1: return '1 - XLEN'($urandom_range(0, 15));
            default: return XLEN'($urandom);
        endcase
    endfunction

    initial begin
        int r0;
        logic [3:0] aop;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_op(A_NONE, B_NONE, M_NONE, 3'd0, 1'b0, '0, '0, '0, '0);
        in_valid = 1'b0;
        x_in_valid = 1'b0; x_alu_op = A_NONE; x_br_op = B_NONE; x_mem_op = M_NONE; x_funct3 = 3'd0;
        x_use_rs2 = 1'b0; x_rs1 = '0; x_rs2 = '0; x_imm = '0; x_pc = '0;
        tick();
        started = 1'b1;
        tick();
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        tick();

        // store address generation
        set_op(A_ADD, B_NONE, M_STORE, 3'd2, 1'b0, 32'd5, 32'hAB, 32'd7, '0);
        tick();
        in_valid = 1'b0;
        chk("pin_model_addr", 64'(m_b.addr), 64'd12);
        chk("st_valid", 64'(out_valid), 64'd1);
        chk("st_write", 64'(mem_write_out), 64'd1);
        chk("st_addr", 64'(mem_addr_out), 64'd12);
        chk("st_data", 64'(mem_data_out), 64'hAB);
        chk("st_mask", 64'(mem_mask_out), 64'hF);
        tick();

        run_div("div", A_DIV, 32'd100, 32'd7, 32'd14);
        run_div("rem", A_REM, 32'd100, 32'd7, 32'd2);
        run_div("div0", A_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_div("rem0", A_REM, 32'd100, 32'd0, 32'd100);

        // branch decisions
        set_op(A_SLT, B_BLT, M_NONE, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        tick();
        chk("blt_taken", 64'(branch_taken_out), 64'd1);
        chk("blt_target", 64'(branch_target_out), 64'h120);
        set_op(A_ADD, B_BEQZ, M_NONE, 3'd0, 1'b0, 32'd0, 32'd0, 32'd8, 32'h40);
        tick();
        chk("beqz_taken", 64'(branch_taken_out), 64'd1);
        set_op(A_ADD, B_JALR, M_NONE, 3'd0, 1'b0, 32'h1001, 32'd0, 32'd2, 32'h500);
        tick();
        in_valid = 1'b0;
        chk("pin_model_jalr", 64'(m_b.tgt), 64'h1002);
        chk("jalr_target", 64'(branch_target_out), 64'h1002);
        tick();

        // load held by backpressure
        out_ready = 1'b0;
        r0 = d_reads;
        set_op(A_ADD, B_NONE, M_LOAD, 3'd2, 1'b0, 32'h200, 32'd0, 32'd4, '0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_read", 64'(mem_read_out), 64'd1);
            chk("hold_addr", 64'(mem_addr_out), 64'h204);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        chk("hold_read_once", 64'(d_reads - r0), 64'd1);

        // reset in the middle of a division
        set_op(A_DIV, B_NONE, M_NONE, 3'd0, 1'b1, 32'd1000, 32'd3, '0, '0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_alu_result), 64'd0);
        reset = 1'b1;
        tick();
        set_op(A_ADD, B_NONE, M_NONE, 3'd0, 1'b1, 32'd3, 32'd4, '0, '0);
        tick();
        in_valid = 1'b0;
        chk("post_rst_add", 64'(out_alu_result), 64'd7);
        for (int i = 0; i < 40; i++) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            aop = 4'($urandom_range(0, 15));
            if ((aop == A_DIV || aop == A_REM) && $urandom_range(0, 3) != 0) aop = A_ADD;
            set_op(aop, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), rv(), rv(), rv(), rv());
            in_valid = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("read_count", 64'(d_reads), 64'(m_reads));

        // 64-bit datapath
        x_alu_op = A_ADD; x_mem_op = M_STORE; x_funct3 = 3'd3; x_rs1 = 64'h1000; x_imm = 64'd8;
        x_rs2 = 64'h1122_3344_5566_7788; x_in_valid = 1'b1;
        @(posedge clk); #1;
        chk("x64_st_write", 64'(x_mw), 64'd1);
        chk("x64_st_mask", 64'(x_mask), 64'hFF);
        chk("x64_st_addr", x_addr, 64'h1008);
        x_alu_op = A_MULH; x_mem_op = M_NONE; x_use_rs2 = 1'b1; x_rs1 = '1; x_rs2 = 64'd2;
        @(posedge clk); #1;
        chk("x64_mulh", x_res, 64'd1);
        x_alu_op = A_ADD; x_mem_op = M_LOAD; x_funct3 = 3'd6; x_use_rs2 = 1'b0; x_rs1 = 64'h40;
        x_imm = 64'd0;
        @(posedge clk); #1;
        x_in_valid = 1'b0;
        chk("x64_ld_read", 64'(x_mr), 64'd1);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
